// File: rtl/golomb_fetch_ctrl.sv
// Fetch/decode sequencer for the Golomb bitstream loop: owns the residual
// window fed back into Combine and paces word fetches against symbol decodes.
module golomb_fetch_ctrl #(
  parameter int MAX_CODE = 32,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] frame_syms,
  input  logic             word_valid,
  input  logic [31:0]      word_data,
  output logic             word_ready,
  output logic             comb_validin,
  output logic [31:0]      comb_word,
  output logic [5:0]       last_len,
  output logic [63:0]      last_bits,
  input  logic [5:0]       comb_len,
  input  logic [63:0]      comb_bits,
  output logic             dec_req,
  input  logic             dec_ack,
  input  logic [5:0]       dec_used,
  output logic [CNT_W-1:0] sym_cnt,
  output logic             busy,
  output logic             done,
  output logic             err
);

  // state  | meaning
  // IDLE   | waiting for the first start after reset
  // FETCH  | one decision: pull a word, pass residual through, or stall
  // WAIT   | Combine register latency
  // DECODE | window valid, waiting for dec_ack
  // DONE   | frame finished or aborted; residual held until next start
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_WAIT, S_DECODE, S_DONE} state_t;

  localparam logic [6:0] MAX_CODE_L = 7'(MAX_CODE);

  state_t           state_q, state_d;
  logic [5:0]       last_len_q, last_len_d;
  logic [63:0]      last_bits_q, last_bits_d;
  logic [CNT_W-1:0] sym_cnt_q, sym_cnt_d;
  logic [CNT_W-1:0] frame_q, frame_d;
  logic             err_q, err_d;
  logic             done_q, done_d;

  always_comb begin
    state_d      = state_q;
    last_len_d   = last_len_q;
    last_bits_d  = last_bits_q;
    sym_cnt_d    = sym_cnt_q;
    frame_d      = frame_q;
    err_d        = err_q;
    done_d       = 1'b0;
    word_ready   = 1'b0;
    comb_validin = 1'b0;
    dec_req      = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          frame_d     = frame_syms;
          last_len_d  = '0;
          last_bits_d = '0;
          sym_cnt_d   = '0;
          err_d       = 1'b0;
          if (frame_syms == '0) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = S_FETCH;
          end
        end
      end
      S_FETCH: begin
        // last_len[5] set means 32+ bits held; fetching then could overflow 63
        if (!last_len_q[5] && word_valid) begin
          word_ready   = 1'b1;
          comb_validin = 1'b1;
          state_d      = S_WAIT;
        end else if (last_len_q[5] ||
                     (({1'b0, last_len_q} >= MAX_CODE_L) && !word_valid)) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: state_d = S_DECODE;
      S_DECODE: begin
        dec_req = 1'b1;
        if (dec_ack) begin
          if ((dec_used == '0) || (dec_used > comb_len)) begin
            err_d   = 1'b1;
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            last_bits_d = comb_bits << dec_used;
            last_len_d  = comb_len - dec_used;
            sym_cnt_d   = sym_cnt_q + CNT_W'(1);
            if (sym_cnt_d == frame_q) begin
              state_d = S_DONE;
              done_d  = 1'b1;
            end else begin
              state_d = S_FETCH;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (rst) begin
      word_ready   = 1'b0;
      comb_validin = 1'b0;
      dec_req      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      last_len_q  <= '0;
      last_bits_q <= '0;
      sym_cnt_q   <= '0;
      frame_q     <= '0;
      err_q       <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_len_q  <= last_len_d;
      last_bits_q <= last_bits_d;
      sym_cnt_q   <= sym_cnt_d;
      frame_q     <= frame_d;
      err_q       <= err_d;
      done_q      <= done_d;
    end
  end

  assign comb_word = word_data;
  assign last_len  = last_len_q;
  assign last_bits = last_bits_q;
  assign sym_cnt   = sym_cnt_q;
  assign err       = err_q;
  assign done      = done_q;
  assign busy      = (state_q == S_FETCH) || (state_q == S_WAIT) || (state_q == S_DECODE);

endmodule

// File: tb/tb_golomb_fetch_ctrl.sv
// Directed bench for golomb_fetch_ctrl; includes a behavioural Combine stage
// that appends the accepted word below the residual window.
module tb_golomb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst, start, word_valid, dec_ack;
  logic [15:0] frame_syms, sym_cnt;
  logic [31:0] word_data, comb_word;
  logic        word_ready, comb_validin, dec_req, busy, done, err;
  logic [5:0]  last_len, comb_len, dec_used;
  logic [63:0] last_bits, comb_bits;

  logic        wvalid = 1'b0;
  logic [31:0] wreg   = '0;
  logic        ovr_en = 1'b0;
  logic [5:0]  ovr_len = '0;

  int n_tests = 0;
  int n_fail  = 0;
  int lat, rdy_cnt;

  always #5 clk = ~clk;

  golomb_fetch_ctrl #(.MAX_CODE(16), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .frame_syms(frame_syms),
    .word_valid(word_valid), .word_data(word_data), .word_ready(word_ready),
    .comb_validin(comb_validin), .comb_word(comb_word),
    .last_len(last_len), .last_bits(last_bits),
    .comb_len(comb_len), .comb_bits(comb_bits),
    .dec_req(dec_req), .dec_ack(dec_ack), .dec_used(dec_used),
    .sym_cnt(sym_cnt), .busy(busy), .done(done), .err(err)
  );

  // Combine model: word captured on validin, held until the window is consumed
  always @(posedge clk) begin
    if (rst) wvalid <= 1'b0;
    else if (comb_validin) begin
      wvalid <= 1'b1;
      wreg   <= word_data;
    end else if (dec_req && dec_ack) wvalid <= 1'b0;
  end

  always_comb begin
    comb_len  = last_len;
    comb_bits = last_bits;
    if (wvalid) begin
      comb_len  = last_len + 6'd32;
      comb_bits = last_bits | ({wreg, 32'h0} >> last_len);
    end
    if (ovr_en) comb_len = ovr_len;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One symbol starting in a FETCH cycle with no stall.
  task automatic sym(input string tag, input logic wv, input logic [31:0] w,
                     input logic exp_rdy, input logic [5:0] used,
                     input logic [5:0] exp_clen, input logic [5:0] exp_len,
                     input logic [63:0] exp_bits);
    word_valid = wv;
    word_data  = w;
    #1;
    chk({tag, "_rdy"}, 64'(word_ready), 64'(exp_rdy));
    chk({tag, "_vin"}, 64'(comb_validin), 64'(exp_rdy));
    tick;
    word_valid = 1'b0;
    chk({tag, "_wait_req"}, 64'(dec_req), 64'd0);
    tick;
    chk({tag, "_req"}, 64'(dec_req), 64'd1);
    chk({tag, "_clen"}, 64'(comb_len), 64'(exp_clen));
    dec_ack  = 1'b1;
    dec_used = used;
    tick;
    dec_ack = 1'b0;
    chk({tag, "_len"}, 64'(last_len), 64'(exp_len));
    chk({tag, "_bits"}, last_bits, exp_bits);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; frame_syms = '0; word_valid = 1'b0;
    word_data = '0; dec_ack = 1'b0; dec_used = '0;
    tick; tick;
    rst = 1'b0;
    chk("rst_outs", 64'({word_ready, comb_validin, dec_req, busy, done, err}), 64'd0);
    chk("rst_len", 64'(last_len), 64'd0);
    chk("rst_bits", last_bits, 64'd0);
    chk("rst_cnt", 64'(sym_cnt), 64'd0);
    word_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1 chk("idle_no_rdy", 64'(word_ready), 64'd0);
      tick;
    end
    word_valid = 1'b0;

    // single symbol
    start = 1'b1; frame_syms = 16'd1;
    tick;
    start = 1'b0;
    sym("single", 1'b1, 32'hF000_0000, 1'b1, 6'd4, 6'd32, 6'd28, 64'h0);
    chk("single_done", 64'(done), 64'd1);
    chk("single_cnt", 64'(sym_cnt), 64'd1);
    chk("single_busy", 64'(busy), 64'd0);
    tick;
    chk("single_done_pulse", 64'(done), 64'd0);

    // refill threshold at 32 residual bits
    start = 1'b1; frame_syms = 16'd4;
    tick;
    start = 1'b0;
    sym("refill1", 1'b1, 32'hA5A5_A5A5, 1'b1, 6'd8, 6'd32, 6'd24, 64'hA5A5_A500_0000_0000);
    sym("refill2", 1'b1, 32'h1234_5678, 1'b1, 6'd24, 6'd56, 6'd32, 64'h1234_5678_0000_0000);
    sym("refill_pass", 1'b1, 32'hFFFF_FFFF, 1'b0, 6'd1, 6'd32, 6'd31, 64'h2468_ACF0_0000_0000);
    sym("refill4", 1'b1, 32'hFFFF_FFFF, 1'b1, 6'd62, 6'd63, 6'd1, 64'h8000_0000_0000_0000);
    chk("refill_done", 64'(done), 64'd1);
    chk("refill_cnt", 64'(sym_cnt), 64'd4);

    // starvation below MAX_CODE, with a start pulse that must be ignored
    start = 1'b1; frame_syms = 16'd2;
    tick;
    start = 1'b0;
    sym("starve1", 1'b1, 32'hDEAD_BEEF, 1'b1, 6'd22, 6'd32, 6'd10, 64'hBBC0_0000_0000_0000);
    frame_syms = 16'd0;
    for (int k = 0; k < 7; k++) begin
      start = (k == 3);
      #1 chk("starve_stall", 64'({word_ready, dec_req, busy}), 64'd1);
      tick;
    end
    start = 1'b0;
    word_valid = 1'b1; word_data = 32'h0000_0001;
    #1 chk("starve_rdy", 64'(word_ready), 64'd1);
    tick;
    word_valid = 1'b0;
    chk("starve_wait", 64'(dec_req), 64'd0);
    tick;
    chk("starve_req", 64'(dec_req), 64'd1);
    chk("starve_clen", 64'(comb_len), 64'd42);
    dec_ack = 1'b1; dec_used = 6'd42;
    tick;
    dec_ack = 1'b0;
    chk("starve_len", 64'(last_len), 64'd0);
    chk("starve_done", 64'({done, sym_cnt}), 64'h1_0002);

    // underflow
    start = 1'b1; frame_syms = 16'd2;
    tick;
    start = 1'b0;
    sym("uflow1", 1'b1, 32'h8F00_0000, 1'b1, 6'd4, 6'd32, 6'd28, 64'hF000_0000_0000_0000);
    #1 chk("uflow_pass", 64'({word_ready, comb_validin}), 64'd0);
    tick; tick;
    chk("uflow_req", 64'(dec_req), 64'd1);
    ovr_en = 1'b1; ovr_len = 6'd5;
    dec_ack = 1'b1; dec_used = 6'd9;
    tick;
    dec_ack = 1'b0; ovr_en = 1'b0;
    chk("uflow_err", 64'({err, done}), 64'd3);
    chk("uflow_len", 64'(last_len), 64'd28);
    chk("uflow_bits", last_bits, 64'hF000_0000_0000_0000);
    chk("uflow_cnt", 64'(sym_cnt), 64'd1);
    tick;
    chk("uflow_sticky", 64'({err, done}), 64'd2);

    // back-to-back, dec_ack held high throughout
    start = 1'b1; frame_syms = 16'd4;
    tick;
    start = 1'b0;
    word_valid = 1'b1; word_data = 32'h0102_0304;
    dec_ack = 1'b1; dec_used = 6'd8;
    #1;
    chk("b2b_err_clr", 64'(err), 64'd0);
    chk("b2b_first_rdy", 64'(word_ready), 64'd1);
    rdy_cnt = 1;
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      tick;
      if (word_ready) rdy_cnt++;
      if (done) begin
        lat = i;
        break;
      end
    end
    dec_ack = 1'b0; word_valid = 1'b0;
    chk("b2b_done_lat", 64'(lat), 64'd12);
    chk("b2b_rdy_cnt", 64'(rdy_cnt), 64'd2);
    chk("b2b_cnt", 64'(sym_cnt), 64'd4);
    chk("b2b_len", 64'(last_len), 64'd32);

    // reset while in DONE with a non-zero residual
    rst = 1'b1;
    tick; tick;
    rst = 1'b0;
    chk("rst2_len", 64'(last_len), 64'd0);
    chk("rst2_cnt", 64'(sym_cnt), 64'd0);
    chk("rst2_outs", 64'({busy, done, err}), 64'd0);

    // reset in FETCH must block the word handshake
    start = 1'b1; frame_syms = 16'd1;
    tick;
    start = 1'b0;
    rst = 1'b1; word_valid = 1'b1; word_data = 32'h5555_AAAA;
    #1 chk("rst_fetch_rdy", 64'({word_ready, comb_validin}), 64'd0);
    tick; tick;
    rst = 1'b0; word_valid = 1'b0;

    // reset held two cycles mid-DECODE
    start = 1'b1; frame_syms = 16'd1;
    tick;
    start = 1'b0;
    word_valid = 1'b1; word_data = 32'hCAFE_0000;
    tick;
    word_valid = 1'b0;
    tick;
    chk("rst_dec_req", 64'(dec_req), 64'd1);
    rst = 1'b1;
    #1 chk("rst_dec_gate", 64'(dec_req), 64'd0);
    tick; tick;
    rst = 1'b0;
    chk("rst_dec_outs", 64'({word_ready, comb_validin, dec_req, busy, done, err}), 64'd0);
    chk("rst_dec_cnt", 64'(sym_cnt), 64'd0);
    word_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1 chk("rst_idle_rdy", 64'(word_ready), 64'd0);
      tick;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
